data_mem_responder: RTL

// Responder end of the per-thread data-memory interface driven by a compute core's LSUs.

---
 rtl/data_mem_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Per-thread data-memory responder: N requesters with a 4-phase valid/ready
// handshake share one single-ported word memory through a round-robin
// access engine with a fixed grant-to-ready latency.
module data_mem_responder #(
  parameter int THREADS_PER_BLOCK  = 4,
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int LATENCY            = 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [THREADS_PER_BLOCK-1:0]                    consumer_read_valid,
  input  logic [THREADS_PER_BLOCK*DATA_MEM_ADDR_BITS-1:0] consumer_read_address,
  output logic [THREADS_PER_BLOCK-1:0]                    consumer_read_ready,
  output logic [THREADS_PER_BLOCK*DATA_MEM_DATA_BITS-1:0] consumer_read_data,
  input  logic [THREADS_PER_BLOCK-1:0]                    consumer_write_valid,
  input  logic [THREADS_PER_BLOCK*DATA_MEM_ADDR_BITS-1:0] consumer_write_address,
  input  logic [THREADS_PER_BLOCK*DATA_MEM_DATA_BITS-1:0] consumer_write_data,
  output logic [THREADS_PER_BLOCK-1:0]                    consumer_write_ready,
  output logic                                            busy
);

  localparam int N     = THREADS_PER_BLOCK;
  localparam int A     = DATA_MEM_ADDR_BITS;
  localparam int D     = DATA_MEM_DATA_BITS;
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             op_write_q, op_write_d;
  logic [A-1:0]     addr_q, addr_d;
  logic [D-1:0]     wdata_q, wdata_d;

  logic [N-1:0]     read_ready_q;
  logic [N-1:0]     write_ready_q;
  logic [D-1:0]     read_data_q [N];

  logic [D-1:0]     mem [2**A];

  logic [A-1:0]     raddr_a [N];
  logic [A-1:0]     waddr_a [N];
  logic [D-1:0]     wdata_a [N];
  logic [N-1:0]     eligible;
  logic             any_eligible;
  logic [PTR_W-1:0] grant_sel;
  logic             complete;
  int               best_off;

  // Unpack flat request buses, qualify eligibility, pack per-thread outputs
  for (genvar gi = 0; gi < N; gi++) begin : g_thread_io
    assign raddr_a[gi] = consumer_read_address[gi*A +: A];
    assign waddr_a[gi] = consumer_write_address[gi*A +: A];
    assign wdata_a[gi] = consumer_write_data[gi*D +: D];
    assign eligible[gi] = (consumer_read_valid[gi] | consumer_write_valid[gi])
                          & ~read_ready_q[gi] & ~write_ready_q[gi];
    assign consumer_read_data[gi*D +: D] = read_data_q[gi];
  end

  assign consumer_read_ready  = read_ready_q;
  assign consumer_write_ready = write_ready_q;
  assign busy                 = (state_q == ACCESS);

  // Round-robin pick: eligible thread at the smallest distance above rr_ptr
  always_comb begin
    best_off     = N;
    grant_sel    = '0;
    any_eligible = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (eligible[j] && (((j - int'(rr_ptr_q) + N) % N) < best_off)) begin
        best_off     = (j - int'(rr_ptr_q) + N) % N;
        grant_sel    = PTR_W'(j);
        any_eligible = 1'b1;
      end
    end
  end

  // Engine next-state: capture request at grant, count down the latency
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    complete   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_eligible) begin
          grant_d    = grant_sel;
          // A thread raising both valids gets its write served first
          op_write_d = consumer_write_valid[grant_sel];
          addr_d     = consumer_write_valid[grant_sel] ? waddr_a[grant_sel]
                                                       : raddr_a[grant_sel];
          wdata_d    = wdata_a[grant_sel];
          rr_ptr_d   = PTR_W'((int'(grant_sel) + 1) % N);
          cnt_d      = 4'(LATENCY - 1);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Memory write port; contents survive reset, an aborted access never writes
  always_ff @(posedge clk) begin
    if (reset && complete && op_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Per-thread handshake: release on valid low, set on own completion only
  for (genvar gi = 0; gi < N; gi++) begin : g_thread_resp
    always_ff @(posedge clk) begin
      if (!reset) begin
        read_ready_q[gi]  <= 1'b0;
        write_ready_q[gi] <= 1'b0;
        read_data_q[gi]   <= '0;
      end else begin
        if (read_ready_q[gi] && !consumer_read_valid[gi]) begin
          read_ready_q[gi] <= 1'b0;
        end
        if (write_ready_q[gi] && !consumer_write_valid[gi]) begin
          write_ready_q[gi] <= 1'b0;
        end
        if (complete && (grant_q == PTR_W'(gi))) begin
          if (op_write_q) begin
            write_ready_q[gi] <= 1'b1;
          end else begin
            read_ready_q[gi] <= 1'b1;
            read_data_q[gi]  <= mem[addr_q];
          end
        end
      end
    end
  end

endmodule
